reset_sequencer: RTL and testbench

- Consumes the PLL/MMCM lock indication produced by the clock unit and runs in the system-clock domain.
- Issues staged, ordered, synchronous-deassert resets to the downstream domains only after lock has been stable for a programmable time.
- Re-asserts all resets on any loss of lock or on a software reset request, and keeps a saturating count of lock-loss events.

---
 rtl/reset_seq_pkg.sv | 19 +
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_sequencer_sync_bit.sv | 25 ++
 rtl/reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_reset_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding,
// lock-loss counter width and a saturating increment helper.
package reset_seq_pkg;

    localparam int LOST_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
        return (&v) ? v : v + LOST_CNT_W'(1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake/status bundle between the clock unit / software side (master)
// and the reset sequencer (slave). o_timeout exists only when
// RESET_SEQ_WATCHDOG_EN is defined.
interface reset_sequencer_if #(
    parameter int N_STAGES = 3
);
    import reset_seq_pkg::*;

    logic                  i_locked;
    logic                  i_sw_reset;
    logic [N_STAGES-1:0]   o_stage_reset;
    logic                  o_ready;
    logic [LOST_CNT_W-1:0] o_lock_lost_count;
    logic [1:0]            o_state;
`ifdef RESET_SEQ_WATCHDOG_EN
    logic                  o_timeout;

    modport master (output i_locked, i_sw_reset,
                    input  o_stage_reset, o_ready, o_lock_lost_count, o_state, o_timeout);
    modport slave  (input  i_locked, i_sw_reset,
                    output o_stage_reset, o_ready, o_lock_lost_count, o_state, o_timeout);
`else
    modport master (output i_locked, i_sw_reset,
                    input  o_stage_reset, o_ready, o_lock_lost_count, o_state);
    modport slave  (input  i_locked, i_sw_reset,
                    output o_stage_reset, o_ready, o_lock_lost_count, o_state);
`endif

endinterface

// File: rtl/reset_sequencer_sync_bit.sv
// Generic single-bit CDC synchroniser, STAGES flops deep, async clear to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    // Shift the asynchronous input one flop deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser chain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for a stable PLL lock, then releases N_STAGES
// active-high resets in order (bit 0 first), STAGE_DELAY cycles apart.
// Any lock loss or software request re-asserts everything at once.
// Optional lock watchdog: define RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int N_STAGES           = 3,
    parameter int CNT_W              = 16,
    parameter int WATCHDOG_CYCLES    = 65535
) (
    input  logic             i_clock,
    input  logic             i_reset,
    reset_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);

    if (SYNC_STAGES < 2 || LOCK_STABLE_CYCLES < 1 || STAGE_DELAY < 1 ||
        N_STAGES < 1 || N_STAGES > 8 || WATCHDOG_CYCLES < 1 ||
        (64'(LOCK_STABLE_CYCLES) >> CNT_W) != 0 || (64'(STAGE_DELAY) >> CNT_W) != 0 ||
        (64'(WATCHDOG_CYCLES) >> CNT_W) != 0) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    logic                  lk;
    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic                  ready_q, ready_d;
    logic [LOST_CNT_W-1:0] lost_q, lost_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (i_clock),
        .rst_n (i_reset),
        .d     (bus.i_locked),
        .q     (lk)
    );

    // Sequencing decisions. Releases shift a zero in from bit 0, so the
    // vector reaching all-zeros means the last stage has been let go.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_rst_d = stage_rst_q;
        ready_d     = 1'b0;
        lost_d      = lost_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d       = '0;
                stage_rst_d = '1;
                if (lk) state_d = ST_STABLE;
            end
            ST_STABLE: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d     = ST_RELEASE;
                    cnt_d       = '0;
                    stage_rst_d = stage_rst_q << 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (stage_rst_q == '0) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end else if (cnt_q == DELAY_LAST) begin
                    cnt_d       = '0;
                    stage_rst_d = stage_rst_q << 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ready_d = 1'b1;
        endcase
        // Lock loss wins over a simultaneous software request so it is counted.
        if (state_q != ST_WAIT_LOCK && (!lk || bus.i_sw_reset)) begin
            state_d     = ST_WAIT_LOCK;
            cnt_d       = '0;
            stage_rst_d = '1;
            ready_d     = 1'b0;
            if (!lk) lost_d = sat_inc(lost_q);
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            lost_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_rst_q <= stage_rst_d;
            ready_q     <= ready_d;
            lost_q      <= lost_d;
        end
    end

    assign bus.o_stage_reset     = stage_rst_q;
    assign bus.o_ready           = ready_q;
    assign bus.o_lock_lost_count = lost_q;
    assign bus.o_state           = state_q;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG_CYCLES);

    logic [CNT_W-1:0] wd_q, wd_d;
    logic             timeout_q, timeout_d;

    // Count time spent without reaching RUN; flag is sticky until i_reset.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (state_d == ST_RUN && state_q != ST_RUN)
            wd_d = '0;
        else if ((state_q == ST_WAIT_LOCK || state_q == ST_STABLE) && wd_q != WD_LIMIT)
            wd_d = wd_q + CNT_W'(1);
        if (wd_d == WD_LIMIT) timeout_d = 1'b1;
    end

    // Watchdog registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a phase-based model (cycles since lock was
// qualified) checked every cycle, plus hand-computed directed checks.
// Watchdog checks are compiled when RESET_SEQ_WATCHDOG_EN is defined.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int L = 8, D = 4, N = 3, S = 2, W = 20;
    localparam int REL_END = L + (N - 1) * D;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    reset_sequencer_if #(.N_STAGES(N)) bus ();

    reset_sequencer #(
        .SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .STAGE_DELAY(D),
        .N_STAGES(N), .CNT_W(16), .WATCHDOG_CYCLES(W)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // p_m = -1 while waiting for lock, else cycles since lock was qualified.
    logic [S-1:0] sync_m;
    int p_m, lost_m, wd_m;
    bit to_m;

    function automatic int st_of(input int p);
        if (p < 0)        return 0;
        if (p < L)        return 1;
        if (p <= REL_END) return 2;
        return 3;
    endfunction

    function automatic int rst_of(input int p);
        int r = 0;
        for (int k = 0; k < N; k++)
            if (!(p >= L + k * D)) r |= (1 << k);
        return r;
    endfunction

    always @(posedge i_clock or negedge i_reset) begin : model
        bit lk;
        int p_old;
        if (!i_reset) begin
            sync_m = '0; p_m = -1; lost_m = 0; wd_m = 0; to_m = 0;
        end else begin
            lk    = sync_m[S-1];
            p_old = p_m;
            if (p_m < 0) begin
                if (lk) p_m = 0;
            end else if (!lk || bus.i_sw_reset) begin
                p_m = -1;
                if (!lk && lost_m < 255) lost_m++;
            end else begin
                p_m++;
            end
            if (st_of(p_old) != 3 && st_of(p_m) == 3) wd_m = 0;
            else if (st_of(p_old) <= 1 && wd_m < W) wd_m++;
            if (wd_m == W) to_m = 1;
            sync_m = {sync_m[S-2:0], bus.i_locked};
        end
    end

    // Compare every cycle outside reset.
    always @(negedge i_clock) begin
        if (i_reset) begin
            check("m_stage_reset", 32'(bus.o_stage_reset), rst_of(p_m));
            check("m_ready", 32'(bus.o_ready), (p_m > REL_END) ? 1 : 0);
            check("m_lost_count", 32'(bus.o_lock_lost_count), lost_m);
            check("m_state", 32'(bus.o_state), st_of(p_m));
`ifdef RESET_SEQ_WATCHDOG_EN
            check("m_timeout", 32'(bus.o_timeout), 32'(to_m));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic wait_ready(input string name, input int max);
        int k = 0;
        while (!bus.o_ready && k < max) begin
            tick();
            k++;
        end
        check(name, 32'(bus.o_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        bus.i_locked   = 1'b0;
        bus.i_sw_reset = 1'b0;
        #23;
        check("rst_stage_reset", 32'(bus.o_stage_reset), 7);
        check("rst_ready", 32'(bus.o_ready), 0);
        check("rst_count", 32'(bus.o_lock_lost_count), 0);
        check("rst_state", 32'(bus.o_state), 0);
        tick();
        i_reset = 1'b1;

        // 1: constant lock -> bit0 at +11, bit1 +15, bit2 +19, ready +20
        bus.i_locked = 1'b1;
        repeat (10) tick();
        check("t1_before_bit0", 32'(bus.o_stage_reset), 7);
        tick();
        check("t1_bit0", 32'(bus.o_stage_reset), 6);
        repeat (3) tick();
        check("t1_before_bit1", 32'(bus.o_stage_reset), 6);
        tick();
        check("t1_bit1", 32'(bus.o_stage_reset), 4);
        repeat (3) tick();
        check("t1_before_bit2", 32'(bus.o_stage_reset), 4);
        tick();
        check("t1_bit2", 32'(bus.o_stage_reset), 0);
        check("t1_ready_low", 32'(bus.o_ready), 0);
        tick();
        check("t1_ready", 32'(bus.o_ready), 1);
        check("t1_state_run", 32'(bus.o_state), 3);
        check("t1_count", 32'(bus.o_lock_lost_count), 0);

        // 3: lock drop in RUN -> reasserted 3 edges later, count 1
        bus.i_locked = 1'b0;
        repeat (2) tick();
        check("t3_still_ready", 32'(bus.o_ready), 1);
        tick();
        check("t3_stage_reset", 32'(bus.o_stage_reset), 7);
        check("t3_ready", 32'(bus.o_ready), 0);
        check("t3_count", 32'(bus.o_lock_lost_count), 1);
        check("t3_state", 32'(bus.o_state), 0);

        // 2: relock, one-cycle glitch early in STABLE
        bus.i_locked = 1'b1;
        repeat (3) tick();
        check("t2_stable", 32'(bus.o_state), 1);
        repeat (2) tick();
        bus.i_locked = 1'b0;
        tick();
        bus.i_locked = 1'b1;
        repeat (2) tick();
        check("t2_state", 32'(bus.o_state), 0);
        check("t2_count", 32'(bus.o_lock_lost_count), 2);
        check("t2_stage_reset", 32'(bus.o_stage_reset), 7);
        wait_ready("t2_ready", 40);

        // 4: software reset in RUN -> re-release after 8+1 cycles
        bus.i_sw_reset = 1'b1;
        tick();
        bus.i_sw_reset = 1'b0;
        check("t4_stage_reset", 32'(bus.o_stage_reset), 7);
        check("t4_state", 32'(bus.o_state), 0);
        check("t4_count", 32'(bus.o_lock_lost_count), 2);
        repeat (8) tick();
        check("t4_before_bit0", 32'(bus.o_stage_reset), 7);
        tick();
        check("t4_bit0", 32'(bus.o_stage_reset), 6);
        wait_ready("t4_ready", 40);

        // 4b: software reset while in WAIT_LOCK is ignored
        bus.i_locked = 1'b0;
        repeat (5) tick();
        check("t4b_count", 32'(bus.o_lock_lost_count), 3);
        bus.i_locked = 1'b1;
        repeat (2) tick();
        bus.i_sw_reset = 1'b1;
        tick();
        bus.i_sw_reset = 1'b0;
        check("t4b_stable", 32'(bus.o_state), 1);
        repeat (7) tick();
        check("t4b_before_bit0", 32'(bus.o_stage_reset), 7);
        tick();
        check("t4b_bit0", 32'(bus.o_stage_reset), 6);
        wait_ready("t4b_ready", 40);

        // 5: 300 further lock losses -> saturates at 255
        for (int i = 0; i < 300; i++) begin
            bus.i_locked = 1'b0;
            repeat (4) tick();
            bus.i_locked = 1'b1;
            repeat (4) tick();
        end
        check("t5_saturated", 32'(bus.o_lock_lost_count), 255);
        wait_ready("t5_ready", 40);
        check("t5_still_sat", 32'(bus.o_lock_lost_count), 255);

        // 6: reset again, lock held low for 20 cycles
        i_reset = 1'b0;
        bus.i_locked = 1'b0;
        #2;
        check("r2_stage_reset", 32'(bus.o_stage_reset), 7);
        check("r2_count", 32'(bus.o_lock_lost_count), 0);
        check("r2_ready", 32'(bus.o_ready), 0);
`ifdef RESET_SEQ_WATCHDOG_EN
        check("r2_timeout", 32'(bus.o_timeout), 0);
`endif
        tick();
        i_reset = 1'b1;
        repeat (19) tick();
`ifdef RESET_SEQ_WATCHDOG_EN
        check("t6_before_timeout", 32'(bus.o_timeout), 0);
`endif
        tick();
`ifdef RESET_SEQ_WATCHDOG_EN
        check("t6_timeout", 32'(bus.o_timeout), 1);
`endif
        bus.i_locked = 1'b1;
        wait_ready("t6_ready", 40);
`ifdef RESET_SEQ_WATCHDOG_EN
        check("t6_sticky", 32'(bus.o_timeout), 1);
        i_reset = 1'b0;
        #2;
        check("t6_cleared", 32'(bus.o_timeout), 0);
`endif
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
